// File: rtl/guess_grade_engine.sv
// Multi-cycle Znarly/Zood grader: exact pass over slots, then an (i,j) pairing pass.
// Optional macro GRADE_EARLY_EXIT_EN skips the pairing pass when every slot matched exactly.
module guess_grade_engine #(
    parameter int NUM_SLOTS  = 4,
    parameter int SHAPE_BITS = 3,
    parameter int CW         = $clog2(NUM_SLOTS + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_SLOTS*SHAPE_BITS-1:0] guess,
    input  logic [NUM_SLOTS*SHAPE_BITS-1:0] master,
    output logic                           busy,
    output logic                           done,
    output logic [CW-1:0]                  znarly,
    output logic [CW-1:0]                  zood,
    output logic                           game_won
);

    localparam int PW = NUM_SLOTS * SHAPE_BITS;
    localparam int IW = $clog2(NUM_SLOTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXACT,
        S_PARTIAL,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          g_q, g_d;
    logic [PW-1:0]          m_q, m_d;
    logic [NUM_SLOTS-1:0]   exact_q, exact_d;
    logic [NUM_SLOTS-1:0]   used_m_q, used_m_d;
    logic [NUM_SLOTS-1:0]   paired_g_q, paired_g_d;
    logic [IW-1:0]          i_q, i_d;
    logic [IW-1:0]          j_q, j_d;
    logic [CW-1:0]          zn_acc_q, zn_acc_d;
    logic [CW-1:0]          zo_acc_q, zo_acc_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CW-1:0]          znarly_q, znarly_d;
    logic [CW-1:0]          zood_q, zood_d;
    logic                   game_won_q, game_won_d;

    logic [SHAPE_BITS-1:0]  g_slot [NUM_SLOTS];
    logic [SHAPE_BITS-1:0]  m_slot [NUM_SLOTS];
    logic                   exact_hit;
    logic                   pair_hit;
    logic [CW-1:0]          zn_new;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_unpack
            assign g_slot[gi] = g_q[gi*SHAPE_BITS +: SHAPE_BITS];
            assign m_slot[gi] = m_q[gi*SHAPE_BITS +: SHAPE_BITS];
        end
    endgenerate

    assign exact_hit = (g_slot[i_q] == m_slot[i_q]);
    // Flags come from the registered copies, so a pairing made this cycle blocks later pairs
    assign pair_hit  = !paired_g_q[i_q] && !used_m_q[j_q] && (g_slot[i_q] == m_slot[j_q]);
    assign zn_new    = exact_hit ? zn_acc_q + CW'(1) : zn_acc_q;

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        m_d        = m_q;
        exact_d    = exact_q;
        used_m_d   = used_m_q;
        paired_g_d = paired_g_q;
        i_d        = i_q;
        j_d        = j_q;
        zn_acc_d   = zn_acc_q;
        zo_acc_d   = zo_acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        znarly_d   = znarly_q;
        zood_d     = zood_q;
        game_won_d = game_won_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    g_d        = guess;
                    m_d        = master;
                    exact_d    = '0;
                    used_m_d   = '0;
                    paired_g_d = '0;
                    zn_acc_d   = '0;
                    zo_acc_d   = '0;
                    i_d        = '0;
                    j_d        = '0;
                    busy_d     = 1'b1;
                    state_d    = S_EXACT;
                end
            end
            S_EXACT: begin
                if (exact_hit) begin
                    exact_d[i_q]    = 1'b1;
                    used_m_d[i_q]   = 1'b1;
                    paired_g_d[i_q] = 1'b1;
                end
                zn_acc_d = zn_new;
                if (i_q == LAST_IDX) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_PARTIAL;
`ifdef GRADE_EARLY_EXIT_EN
                    if (zn_new == CW'(NUM_SLOTS)) begin
                        state_d = S_DONE;
                    end
`endif
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_PARTIAL: begin
                if (pair_hit) begin
                    paired_g_d[i_q] = 1'b1;
                    used_m_d[j_q]   = 1'b1;
                    zo_acc_d        = zo_acc_q + CW'(1);
                end
                if (j_q == LAST_IDX) begin
                    j_d = '0;
                    if (i_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            S_DONE: begin
                done_d     = 1'b1;
                znarly_d   = zn_acc_q;
                zood_d     = zo_acc_q;
                game_won_d = &exact_q;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            g_q        <= '0;
            m_q        <= '0;
            exact_q    <= '0;
            used_m_q   <= '0;
            paired_g_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            zn_acc_q   <= '0;
            zo_acc_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            znarly_q   <= '0;
            zood_q     <= '0;
            game_won_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            m_q        <= m_d;
            exact_q    <= exact_d;
            used_m_q   <= used_m_d;
            paired_g_q <= paired_g_d;
            i_q        <= i_d;
            j_q        <= j_d;
            zn_acc_q   <= zn_acc_d;
            zo_acc_q   <= zo_acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            znarly_q   <= znarly_d;
            zood_q     <= zood_d;
            game_won_q <= game_won_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign znarly   = znarly_q;
    assign zood     = zood_q;
    assign game_won = game_won_q;

endmodule

// File: tb/tb_guess_grade_engine.sv
// Scoreboard bench for guess_grade_engine: stimulus pushes expected results, a monitor checks each done.
module tb_guess_grade_engine;

    localparam int NS = 4;
    localparam int SB = 3;
    localparam int CW = $clog2(NS + 1);
`ifdef GRADE_EARLY_EXIT_EN
    localparam int WIN_LAT = NS + 1;
`else
    localparam int WIN_LAT = NS + NS * NS + 1;
`endif
    localparam int FULL_LAT = NS + NS * NS + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [NS*SB-1:0]    guess;
    logic [NS*SB-1:0]    master;
    logic                busy;
    logic                done;
    logic [CW-1:0]       znarly;
    logic [CW-1:0]       zood;
    logic                game_won;

    typedef struct {
        int zn;
        int zo;
        int won;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    guess_grade_engine #(.NUM_SLOTS(NS), .SHAPE_BITS(SB)) dut (
        .clock   (clk),
        .reset   (reset),
        .start   (start),
        .guess   (guess),
        .master  (master),
        .busy    (busy),
        .done    (done),
        .znarly  (znarly),
        .zood    (zood),
        .game_won(game_won)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("znarly", int'(znarly), e.zn);
                chk("zood", int'(zood), e.zo);
                chk("game_won", int'(game_won), e.won);
                $display("grade done at cycle %0d: znarly=%0d zood=%0d won=%0d", cyc, znarly, zood, game_won);
            end
        end
    end

    // Issue one grade from a negedge; returns cycle index of the sampling edge
    task automatic issue(input logic [NS*SB-1:0] g, input logic [NS*SB-1:0] m,
                         input int zn, input int zo, input bit push, output int c0);
        exp_t e;
        guess  = g;
        master = m;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0    = cyc;
        chk("busy_after_start", int'(busy), 1);
        if (push) begin
            e.zn  = zn;
            e.zo  = zo;
            e.won = (zn == NS) ? 1 : 0;
            e.cyc = c0 + ((zn == NS) ? WIN_LAT : FULL_LAT);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    logic [NS*SB-1:0] win_v;
    logic [NS*SB-1:0] mix_g;
    int               c0;
    exp_t             e2;

    initial begin
        win_v  = 12'b101_110_100_001;
        mix_g  = 12'b101_011_001_110;
        reset  = 1'b1;
        start  = 1'b0;
        guess  = '0;
        master = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_znarly", int'(znarly), 0);
        chk("reset_zood", int'(zood), 0);
        chk("reset_won", int'(game_won), 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: exact win
        issue(win_v, win_v, 4, 0, 1'b1, c0);
        wait_drain();
        // 2: mixed match
        issue(mix_g, win_v, 1, 2, 1'b1, c0);
        wait_drain();
        // 3: duplicate consumption
        issue(12'b001_001_100_010, 12'b011_011_100_100, 1, 0, 1'b1, c0);
        wait_drain();
        issue(12'b010_001_010_010, 12'b001_001_001_010, 2, 0, 1'b1, c0);
        wait_drain();

        // 4a: start while busy is ignored, and input changes do not disturb the grade
        issue(mix_g, win_v, 1, 2, 1'b1, c0);
        repeat (2) @(negedge clk);
        guess = win_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);

        // 4b: start held high gives back-to-back grades
        guess  = win_v;
        master = win_v;
        start  = 1'b1;
        @(negedge clk);
        c0 = cyc;
        e2.zn = 4; e2.zo = 0; e2.won = 1; e2.cyc = c0 + WIN_LAT;
        exp_q.push_back(e2);
        e2.cyc = c0 + 2 * WIN_LAT + 1;
        exp_q.push_back(e2);
        repeat (WIN_LAT + 1) @(negedge clk);
        start = 1'b0;
        chk("busy_second_grade", int'(busy), 1);
        wait_drain();

        // 5: reset mid-grade clears outputs immediately and drops the grade
        issue(mix_g, win_v, 0, 0, 1'b0, c0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_znarly", int'(znarly), 0);
        chk("midrst_zood", int'(zood), 0);
        chk("midrst_won", int'(game_won), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        issue(mix_g, win_v, 1, 2, 1'b1, c0);
        wait_drain();

        // 6: no match, then results hold while inputs wander
        issue(12'b010_011_100_101, 12'b001_001_001_001, 0, 0, 1'b1, c0);
        wait_drain();
        for (int k = 0; k < 10; k++) begin
            guess  = win_v;
            master = win_v;
            @(negedge clk);
            chk("hold_znarly", int'(znarly), 0);
            chk("hold_zood", int'(zood), 0);
            chk("hold_done", int'(done), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/guess_grade_engine.md
Name: guess_grade_engine

Overview:
- Parametrised, multi-cycle successor to the fixed 4-slot combinational guess checker.
- Grades a guess of NUM_SLOTS shapes against a master pattern of NUM_SLOTS shapes:
  - Znarly: right shape in the right slot.
  - Zood: right shape in the wrong slot, with each shape consumed at most once, so duplicates are handled correctly.
- Sits between the game FSM (drives start, latches results on done) and the display/round logic.

Parameters:
- NUM_SLOTS, 4, number of shape slots per pattern (2..8).
- SHAPE_BITS, 3, width of one shape code.
- CW, $clog2(NUM_SLOTS+1), width of the Znarly/Zood counts (derived; do not override).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request grading; sampled only in IDLE.
- guess  in  NUM_SLOTS*SHAPE_BITS  guess pattern; slot k = bits [k*SHAPE_BITS +: SHAPE_BITS], slot 0 at the LSBs.
- master  in  NUM_SLOTS*SHAPE_BITS  master pattern, same slot layout as guess.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid and updated in the same cycle.
- znarly  out  CW  exact-position match count.
- zood  out  CW  right-shape/wrong-slot count.
- game_won  out  1  znarly == NUM_SLOTS at last grade.

Behaviour:
- Reset (async, active-high): state = IDLE; busy, done, znarly, zood, game_won = 0; all internal flags and counters cleared. Reset mid-grade aborts the grade; no done pulse is produced.
- IDLE:
  - If start = 1: capture guess and master into internal registers, clear exact[], used_m[] and paired_g[] flags and both accumulators, set i = 0, go to EXACT.
  - Input changes after capture have no effect on the grade in progress.
- EXACT, one cycle per slot i = 0..NUM_SLOTS-1:
  - If g[i] == m[i]: set exact[i], used_m[i], paired_g[i], and increment the Znarly accumulator.
  - After i = NUM_SLOTS-1: go to PARTIAL with i = 0, j = 0.
- PARTIAL, one cycle per (i, j) pair, j inner loop, NUM_SLOTS*NUM_SLOTS cycles total:
  - If !paired_g[i] && !used_m[j] && g[i] == m[j]: set paired_g[i] and used_m[j], and increment the Zood accumulator.
  - Flags set in a cycle are visible in the next cycle, so one guess slot pairs with at most one master slot.
  - After (NUM_SLOTS-1, NUM_SLOTS-1): go to DONE.
- DONE, one cycle:
  - done = 1.
  - znarly, zood and game_won are loaded from the accumulators.
  - Return to IDLE.
- busy = 1 in EXACT, PARTIAL and DONE.
- Latency: done asserts exactly NUM_SLOTS + NUM_SLOTS^2 + 1 cycles after the start-sampling edge (21 for NUM_SLOTS = 4).
- start while busy: ignored, not queued.
- start held high: a new grade begins on the cycle after DONE.
- Results hold between grades; they change only in the DONE cycle or on reset.
- Arithmetic: znarly + zood <= NUM_SLOTS always; accumulators are CW bits wide and cannot overflow.
- Shape codes are compared raw; no shape value is treated as reserved.

Optional Feature:
- Macro: GRADE_EARLY_EXIT_EN.
- Defined:
  - On leaving EXACT with the Znarly accumulator == NUM_SLOTS, skip PARTIAL and go directly to DONE.
  - Winning-guess latency becomes NUM_SLOTS + 1 cycles (5 for NUM_SLOTS = 4).
  - Non-winning guesses keep the full latency.
- Undefined: always traverse PARTIAL; latency is fixed for every guess.
- Result values are identical in both builds.

Test Plan (NUM_SLOTS = 4, SHAPE_BITS = 3):
1. Exact win: master = guess = 101_110_100_001, pulse start.
   - Required: done exactly 21 cycles later; znarly = 4, zood = 0, game_won = 1.
   - With GRADE_EARLY_EXIT_EN defined: done after 5 cycles, same results.
2. Mixed match: master 101_110_100_001, guess 101_011_001_110.
   - Required: znarly = 1, zood = 2, game_won = 0.
3. Duplicate consumption:
   - master 011_011_100_100 / guess 001_001_100_010 -> znarly = 1, zood = 0.
   - master 001_001_001_010 / guess 010_001_010_010 -> znarly = 2, zood = 0 (no Zood double-count).
4. Busy/start interaction:
   - Pulse start, change guess and re-pulse start 3 cycles later -> single done at +21 with results from the first capture.
   - Hold start high -> back-to-back grades, with done pulses 22 cycles apart.
5. Reset mid-grade: assert reset 10 cycles into a grade.
   - Required: busy = 0 and all outputs = 0 immediately; no done pulse.
   - Next start grades correctly from scratch.
6. No match: master 001_001_001_001, guess 010_011_100_101.
   - Required: znarly = 0, zood = 0.
   - Outputs then hold those values unchanged for 10 idle cycles.
